// File: rtl/freq_comp_stream.sv
// Streams a segment of a compensation-factor table through a valid/ready port.
// Optional COMP_CONJ_EN: conjugate factors of segments started with inv=1.
module freq_comp_stream #(
    parameter int DATA_W = 26,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 9000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] seg_len,
    input  logic              inv,
    output logic [DATA_W-1:0] comp_data,
    output logic              comp_valid,
    input  logic              comp_ready,
    output logic              comp_last,
    output logic              busy,
    output logic              err
);

    localparam int H = DATA_W / 2;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic              err_q;
    logic              rd_vld;
    logic              rd_last_q;
    logic [DATA_W-1:0] sk_d [2];
    logic              sk_l [2];
    logic [1:0]        sk_cnt;

    logic              rd_en;
    logic              rd_last;
    logic [ADDR_W:0]   seg_end;
    logic              seg_ok;
    logic              acc;
    logic              pop;
    logic              push;
    logic              wr_sel;
    logic [1:0]        occ;
    logic              room;
    logic [DATA_W-1:0] raw;

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_C))
            mem[wr_addr] <= wr_data;
        if (rd_en)
            mem_q <= mem[addr_q];
    end

    assign seg_end = {1'b0, base_addr} + {1'b0, seg_len};
    assign seg_ok  = (seg_len != '0) && (seg_end <= DEPTH_C);

    assign comp_valid = (sk_cnt != 2'd0) || rd_vld;
    assign acc        = comp_valid && comp_ready;
    assign pop        = acc && (sk_cnt != 2'd0);
    assign push       = rd_vld && !(acc && (sk_cnt == 2'd0));
    assign wr_sel     = (sk_cnt == 2'd2) || ((sk_cnt == 2'd1) && !pop);

    // A new read may only issue if its result is guaranteed a slot
    assign occ  = sk_cnt + {1'b0, rd_vld};
    assign room = (occ - {1'b0, acc}) <= 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && seg_ok) state_nx = RUN;
            RUN:     if (rd_last) state_nx = DRAIN;
            DRAIN:   if (acc && comp_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_last = 1'b0;
        busy    = (state != IDLE);
        if (state == RUN) begin
            rd_en   = room;
            rd_last = room && (rem_q == ADDR_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last_q <= 1'b0;
            sk_d[0]   <= '0;
            sk_d[1]   <= '0;
            sk_l[0]   <= 1'b0;
            sk_l[1]   <= 1'b0;
            sk_cnt    <= 2'd0;
        end else begin
            err_q     <= start && ((state != IDLE) || !seg_ok);
            rd_vld    <= rd_en;
            rd_last_q <= rd_last;
            if ((state == IDLE) && start && seg_ok) begin
                addr_q <= base_addr;
                rem_q  <= seg_len;
            end else if (rd_en) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - ADDR_W'(1);
            end
            if (pop) begin
                sk_d[0] <= sk_d[1];
                sk_l[0] <= sk_l[1];
            end
            if (push) begin
                sk_d[wr_sel] <= mem_q;
                sk_l[wr_sel] <= rd_last_q;
            end
            sk_cnt <= sk_cnt - {1'b0, pop} + {1'b0, push};
        end
    end

    assign err = err_q;

    always_comb begin
        raw       = '0;
        comp_last = 1'b0;
        if (sk_cnt != 2'd0) begin
            raw       = sk_d[0];
            comp_last = sk_l[0];
        end else if (rd_vld) begin
            raw       = mem_q;
            comp_last = rd_last_q;
        end
    end

`ifdef COMP_CONJ_EN
    logic         inv_q;
    logic [H-1:0] im;
    logic [H-1:0] im_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if ((state == IDLE) && start && seg_ok)
            inv_q <= inv;
    end

    // Negating the most-negative imag would wrap, so clamp to max positive
    assign im   = raw[H-1:0];
    assign im_n = (im == {1'b1, {(H-1){1'b0}}}) ? {1'b0, {(H-1){1'b1}}} : -im;
    assign comp_data = inv_q ? {raw[DATA_W-1:H], im_n} : raw;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign comp_data  = raw;
`endif

endmodule

// File: tb/tb_freq_comp_stream.sv
// Scoreboard bench for freq_comp_stream.
// Define COMP_CONJ_EN for both files to exercise conjugation.
module tb_freq_comp_stream;

    localparam int DATA_W = 26;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 9000;
    localparam int H      = DATA_W / 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] seg_len = '0;
    logic              inv = 1'b0;
    logic [DATA_W-1:0] comp_data;
    logic              comp_valid;
    logic              comp_ready = 1'b1;
    logic              comp_last;
    logic              busy;
    logic              err;

    freq_comp_stream #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .seg_len(seg_len), .inv(inv),
        .comp_data(comp_data), .comp_valid(comp_valid),
        .comp_ready(comp_ready), .comp_last(comp_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [DATA_W:0] sb [$];
    logic [DATA_W-1:0] model [int];
    logic            prev_stall = 1'b0;
    logic [DATA_W:0] prev_pkt;
    logic [DATA_W:0] exp_pkt;

    function automatic logic [DATA_W-1:0] expect_val(
        input logic [DATA_W-1:0] d, input logic iv);
`ifdef COMP_CONJ_EN
        logic [H-1:0] im;
        im = d[H-1:0];
        if (!iv) return d;
        if (im == {1'b1, {(H-1){1'b0}}}) return {d[DATA_W-1:H], {1'b0, {(H-1){1'b1}}}};
        return {d[DATA_W-1:H], -im};
`else
        if (iv) return d;
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!comp_valid || {comp_last, comp_data} !== prev_pkt) begin
                    fails++;
                    $display("FAIL hold: got v=%0b %0h expected %0h", comp_valid,
                             {comp_last, comp_data}, prev_pkt);
                end
            end
            if (comp_valid && comp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected: got %0h expected nothing", {comp_last, comp_data});
                end else begin
                    exp_pkt = sb.pop_front();
                    if ({comp_last, comp_data} !== exp_pkt) begin
                        fails++;
                        $display("FAIL data: got %0h expected %0h", {comp_last, comp_data}, exp_pkt);
                    end
                end
            end
            prev_stall = comp_valid && !comp_ready;
            prev_pkt   = {comp_last, comp_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic start_seg(input int b, input int l, input logic iv, input logic exp_err);
        logic [DATA_W-1:0] v;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        seg_len   = ADDR_W'(l);
        inv       = iv;
        if (!exp_err) begin
            for (int i = 0; i < l; i++) begin
                v = expect_val(model[b + i], iv);
                sb.push_back({(i == l - 1), v});
            end
        end
        tick();
        start = 1'b0;
        check("err_pulse", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy && sb.size() == 0) break;
            tick();
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_valid", {31'd0, comp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", 32'(comp_data), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write(i, DATA_W'(i));
        for (int i = 8990; i < 9000; i++) write(i, DATA_W'(i));

        start_seg(4, 3, 1'b0, 1'b0);
        check("lat_v1", {31'd0, comp_valid}, 32'd0);
        check("busy_on", {31'd0, busy}, 32'd1);
        tick();
        check("lat_v2", {31'd0, comp_valid}, 32'd1);
        check("err_clear", {31'd0, err}, 32'd0);
        wait_idle();
        check("valid_after", {31'd0, comp_valid}, 32'd0);

        begin
            logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            comp_ready = pat[0];
            start_seg(4, 3, 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) begin
                comp_ready = pat[k];
                tick();
            end
            comp_ready = 1'b1;
            wait_idle();
        end

        start_seg(8990, 11, 1'b0, 1'b1);
        check("oor_valid", {31'd0, comp_valid}, 32'd0);
        tick();
        check("oor_err_once", {31'd0, err}, 32'd0);
        check("oor_busy", {31'd0, busy}, 32'd0);
        start_seg(5, 0, 1'b0, 1'b1);
        tick();
        check("len0_valid", {31'd0, comp_valid}, 32'd0);
        start_seg(8990, 10, 1'b0, 1'b0);
        wait_idle();

        comp_ready = 1'b0;
        start_seg(4, 3, 1'b0, 1'b0);
        tick();
        tick();
        start_seg(10, 2, 1'b0, 1'b1);
        comp_ready = 1'b1;
        wait_idle();

        start_seg(0, 8, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, comp_valid}, 32'd0);
        check("mid_rst_last", {31'd0, comp_last}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", 32'(comp_data), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_seg(0, 2, 1'b0, 1'b0);
        wait_idle();

        write(20, {13'd100, 13'h1FFB});
        write(21, {13'd100, 13'h1000});
        start_seg(20, 2, 1'b1, 1'b0);
        wait_idle();
        start_seg(20, 2, 1'b0, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/freq_comp_stream.md
FREQ_COMP_STREAM -- requirements
Module: freq_comp_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 26, meaning packed complex factor width: real in [DATA_W-1:DATA_W/2], imag in [DATA_W/2-1:0]; DATA_W even.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning table address width.
REQ-003 SHALL have parameter DEPTH, default 9000, meaning table entries; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  table write strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_W  table write address.
REQ-008 SHALL have port wr_data  input  DATA_W  table write data.
REQ-009 SHALL have port start  input  1  one-cycle request to stream a segment.
REQ-010 SHALL have port base_addr  input  ADDR_W  first entry of segment, sampled on start.
REQ-011 SHALL have port seg_len  input  ADDR_W  entry count of segment, sampled on start.
REQ-012 SHALL have port inv  input  1  inverse-transform flag, sampled on start.
REQ-013 SHALL have port comp_data  output  DATA_W  compensation factor.
REQ-014 SHALL have port comp_valid  output  1  comp_data valid.
REQ-015 SHALL have port comp_ready  input  1  downstream accepts on comp_valid & comp_ready.
REQ-016 SHALL have port comp_last  output  1  marks final factor of segment.
REQ-017 SHALL have port busy  output  1  segment in progress.
REQ-018 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-019 SHALL hold DEPTH x DATA_W table written synchronously when wr_en=1 and wr_addr<DEPTH; wr_addr>=DEPTH ignored.
REQ-020 SHALL read table synchronously (1-cycle); same-cycle read/write of one address returns old data.
REQ-021 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-022 IDLE: start with seg_len!=0 and base_addr+seg_len<=DEPTH (computed ADDR_W+1 bits) latches base_addr/seg_len/inv, sets busy next cycle, enters RUN.
REQ-023 IDLE: start with seg_len=0 or out-of-range segment pulses err next cycle, stays IDLE, no output.
REQ-024 RUN/DRAIN: start ignored, err pulses next cycle, current segment unaffected.
REQ-025 RUN issues one read per cycle while 2-entry output skid buffer has room after in-flight read; address increments by 1 from base_addr; after seg_len reads enters DRAIN.
REQ-026 DRAIN -> IDLE once last factor accepted; busy deasserts the cycle after acceptance.
REQ-027 First comp_valid SHALL assert 2 cycles after start with comp_ready=1; throughput 1 factor/cycle with comp_ready held high.
REQ-028 comp_data/comp_last SHALL stay stable while comp_valid=1 and comp_ready=0; no factor dropped or duplicated.
REQ-029 comp_last SHALL assert only with the seg_len-th factor.
REQ-030 Writes SHALL be accepted in any state; a factor reflects table contents at its read cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, comp_valid=0, comp_last=0, busy=0, err=0, comp_data=0, skid buffer empty, address/count cleared.
REQ-032 Table contents SHALL not be reset; reset mid-segment discards remaining factors; first start after release behaves as REQ-022.

Configuration
REQ-033 Macro COMP_CONJ_EN defined: factor streamed with latched inv=1 SHALL have imag negated (two's complement; most-negative imag saturates to most-positive), real unchanged.
REQ-034 COMP_CONJ_EN undefined: inv SHALL be ignored and factors output exactly as stored.

Verification
REQ-035 Write entries 0..15 with value i; start base=4, len=3, ready=1 -> valid at cycles +2..+4, data 4,5,6, last with 6, busy low after.
REQ-036 Same segment, comp_ready toggled 1,0,0,1,0,1 -> data sequence 4,5,6 exactly once each, held stable while stalled.
REQ-037 start base=8990, len=11 (DEPTH 9000) -> err one pulse, no comp_valid; len=0 -> err; start during busy -> err, segment completes intact.
REQ-038 COMP_CONJ_EN, entry real=100 imag=-5 (13-bit halves), inv=1 -> imag=+5; imag=-4096 -> +4095; inv=0 -> unchanged.
REQ-039 rst_n low at 2nd factor of len=8 segment -> all outputs 0 immediately; new start base=0 len=2 -> data 0,1 with last.
